// File: rtl/alu_result_decoder.sv
// Output-side decoder for the add/subtract ALU: registers the raw adder result, then
// produces N/Z/C/V flags and the sign-magnitude form of the exact signed result.
module alu_result_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Result,
  input  logic             CarryOut,
  input  logic             A_msb,
  input  logic             B_msb,
  input  logic             ALUControl_0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Mag,
  output logic             Sign,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic             s1_carry;
  logic             s1_a_msb;
  logic             s1_b_msb;
  logic             s1_sub;
  logic             s2_valid;
  logic             s1_advance;

  logic             n_d;
  logic             z_d;
  logic             v_d;
  logic             sign_d;
  logic [WIDTH:0]   t_d;
  logic [WIDTH:0]   mag_d;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_carry  <= 1'b0;
      s1_a_msb  <= 1'b0;
      s1_b_msb  <= 1'b0;
      s1_sub    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_result <= Result;
        s1_carry  <= CarryOut;
        s1_a_msb  <= A_msb;
        s1_b_msb  <= B_msb;
        s1_sub    <= ALUControl_0;
      end
    end
  end

  // Overflow: for subtract the effective B sign is inverted, so the operand-sign test flips.
  always_comb begin
    n_d    = s1_result[WIDTH-1];
    z_d    = (s1_result == '0);
    v_d    = s1_sub ? ((s1_a_msb != s1_b_msb) && (n_d != s1_a_msb))
                    : ((s1_a_msb == s1_b_msb) && (n_d != s1_a_msb));
    sign_d = n_d ^ v_d;
    t_d    = {sign_d, s1_result};
    mag_d  = sign_d ? (~t_d + (WIDTH+1)'(1)) : t_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      Mag      <= '0;
      Sign     <= 1'b0;
      N        <= 1'b0;
      Z        <= 1'b0;
      C        <= 1'b0;
      V        <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Mag  <= mag_d;
        Sign <= sign_d;
        N    <= n_d;
        Z    <= z_d;
        C    <= s1_carry;
        V    <= v_d;
      end
    end
  end

endmodule
